// File: rtl/uc_pkg.sv
// uc_pkg: shared opcodes, FSM states, instruction field positions and mux polarity for unidad_control
package uc_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ALU  = 4'd1,
    OP_ALUI = 4'd2,
    OP_SHF  = 4'd3,
    OP_LD   = 4'd4,
    OP_ST   = 4'd5
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MEM  = 2'd2
  } state_e;
  // Field tops measured down from the instruction MSB: field = ir[IW-OFS -: width]
  localparam int OP_OFS  = 1;
  localparam int DST_OFS = 5;
  localparam int SA_OFS  = 7;
  localparam int SB_OFS  = 9;
  localparam int HS_OFS  = 11;
  localparam int FN_OFS  = 13;
  localparam logic MB_CONST = 1'b1;
  localparam logic MF_ALU   = 1'b1;
  localparam logic MD_FUNC  = 1'b1;
  function automatic logic op_is_mem(input logic [3:0] op);
    return op == OP_LD || op == OP_ST;
  endfunction
endpackage

// File: rtl/uc_decode.sv
// uc_decode: combinational decode of the latched instruction into datapath selects and an op classification
module uc_decode
  import uc_pkg::*;
#(
  parameter int M  = 8,
  parameter int IW = 16 + M
) (
  input  logic [IW-1:0] ir_i,
  output logic [1:0]    a_sel_o,
  output logic [1:0]    b_sel_o,
  output logic [1:0]    dst_sel_o,
  output logic [1:0]    h_sel_o,
  output logic [3:0]    g_sel_o,
  output logic [M-1:0]  cons_o,
  output logic          mb_sel_o,
  output logic          md_sel_o,
  output logic          mf_sel_o,
  output logic          is_rf_o,
  output logic          is_mem_o,
  output logic          is_write_o,
  output logic          is_illegal_o
);
  logic [3:0] op;
  assign op        = ir_i[IW-OP_OFS -: 4];
  assign dst_sel_o = ir_i[IW-DST_OFS -: 2];
  assign a_sel_o   = ir_i[IW-SA_OFS -: 2];
  assign b_sel_o   = ir_i[IW-SB_OFS -: 2];
  assign h_sel_o   = ir_i[IW-HS_OFS -: 2];
  assign g_sel_o   = ir_i[IW-FN_OFS -: 4];
  assign cons_o    = ir_i[M-1:0];
  always_comb begin
    is_rf_o      = op == OP_ALU || op == OP_ALUI || op == OP_SHF;
    is_mem_o     = op_is_mem(op);
    is_write_o   = op == OP_ST;
    is_illegal_o = op > OP_ST;
    mb_sel_o     = op == OP_ALUI ? MB_CONST : ~MB_CONST;
    mf_sel_o     = (op == OP_ALU || op == OP_ALUI) ? MF_ALU : ~MF_ALU;
    // Only register-writing ops route the function bus; LD (and idle NOP) select Data_IN
    md_sel_o     = is_rf_o ? MD_FUNC : ~MD_FUNC;
  end
endmodule

// File: rtl/unidad_control.sv
// unidad_control: multi-cycle control FSM for the 4-register datapath with memory handshake and timeout
module unidad_control
  import uc_pkg::*;
#(
  parameter int M  = 8,
  parameter int IW = 16 + M,
  parameter int TO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [1:0]    A_sel,
  output logic [1:0]    B_sel,
  output logic [1:0]    Dest_sel,
  output logic [1:0]    H_sel,
  output logic [3:0]    G_sel,
  output logic [M-1:0]  Cons_IN,
  output logic          MB_sel,
  output logic          MD_sel,
  output logic          MF_sel,
  output logic          Load_en,
  input  logic [3:0]    Tags,
  output logic          mem_req,
  output logic          mem_we,
  input  logic          mem_ack,
  output logic          done,
  output logic          err,
  output logic [3:0]    flags
);
  localparam int CW = TO > 1 ? $clog2(TO) : 1;
  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [3:0]    flags_q, flags_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_rf, is_mem, is_write, is_illegal;
  logic          accept, in_exec, in_mem, expired, mem_fin;
  uc_decode #(.M(M), .IW(IW)) u_dec (
    .ir_i(ir_q),
    .a_sel_o(A_sel),
    .b_sel_o(B_sel),
    .dst_sel_o(Dest_sel),
    .h_sel_o(H_sel),
    .g_sel_o(G_sel),
    .cons_o(Cons_IN),
    .mb_sel_o(MB_sel),
    .md_sel_o(MD_sel),
    .mf_sel_o(MF_sel),
    .is_rf_o(is_rf),
    .is_mem_o(is_mem),
    .is_write_o(is_write),
    .is_illegal_o(is_illegal)
  );
  always_comb begin
    in_exec     = state_q == S_EXEC;
    in_mem      = state_q == S_MEM && is_mem;
    instr_ready = state_q == S_IDLE;
    accept      = instr_ready && instr_valid;
    // A same-cycle ack beats the timeout
    expired     = in_mem && !mem_ack && cnt_q == CW'(TO - 1);
    mem_fin     = in_mem && (mem_ack || expired);
    mem_req     = in_mem;
    mem_we      = in_mem && is_write;
    Load_en     = (in_exec && is_rf) || (in_mem && mem_ack && !is_write);
    done        = in_exec || mem_fin;
    err         = (in_exec && is_illegal) || expired;
    flags       = flags_q;
    ir_d        = accept ? instr : ir_q;
    flags_d     = in_exec && is_rf ? Tags : flags_q;
    cnt_d       = in_mem ? cnt_q + 1'b1 : '0;
    state_d     = accept ? (op_is_mem(instr[IW-OP_OFS -: 4]) ? S_MEM : S_EXEC) :
                  (in_exec || mem_fin || state_q == S_MEM && !is_mem) ? S_IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_unidad_control.sv
// tb_unidad_control: directed-vector bench for unidad_control with hand-computed expectations
module tb_unidad_control;
  localparam int M  = 8;
  localparam int IW = 16 + M;
  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    A_sel, B_sel, Dest_sel, H_sel;
  logic [3:0]    G_sel;
  logic [M-1:0]  Cons_IN;
  logic          MB_sel, MD_sel, MF_sel, Load_en;
  logic [3:0]    Tags;
  logic          mem_req, mem_we, mem_ack, done, err;
  logic [3:0]    flags;
  int            n_vec = 0;
  int            n_bad = 0;
  int            req_cycles;
  unidad_control #(.M(M), .IW(IW), .TO(15)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .A_sel(A_sel), .B_sel(B_sel), .Dest_sel(Dest_sel), .H_sel(H_sel), .G_sel(G_sel),
    .Cons_IN(Cons_IN), .MB_sel(MB_sel), .MD_sel(MD_sel), .MF_sel(MF_sel), .Load_en(Load_en),
    .Tags(Tags), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .done(done),
    .err(err), .flags(flags)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] hs, input logic [3:0] fn,
                                       input logic [7:0] imm);
    return {op, dst, sa, sb, hs, fn, imm};
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0; Tags = 4'h0; mem_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_flags", flags, 0);
    chk("rst_outs", {mem_req, mem_we, done, err, Load_en, MB_sel, MD_sel, MF_sel}, 0);
    // ALU r2 <- r1 op0 r3
    instr = mk(4'd1, 2'd2, 2'd1, 2'd3, 2'd0, 4'd0, 8'h00); instr_valid = 1'b1;
    step();
    instr = mk(4'd2, 2'd1, 2'd0, 2'd0, 2'd0, 4'd6, 8'h5A); Tags = 4'b1010;
    #1;
    chk("alu_sels", {G_sel, A_sel, B_sel, Dest_sel}, {4'd0, 2'd1, 2'd3, 2'd2});
    chk("alu_mux", {MB_sel, MF_sel, MD_sel}, 3'b011);
    chk("alu_ld_done_err", {Load_en, done, err}, 3'b110);
    chk("alu_busy", instr_ready, 0);
    step();
    chk("alu_flags", flags, 4'b1010);
    chk("alu_done_once", {done, Load_en, instr_ready}, 3'b001);
    // ALUI was held valid through EXEC; taken at this edge only
    step();
    instr_valid = 1'b0; Tags = 4'b0101;
    #1;
    chk("alui_cons", Cons_IN, 8'h5A);
    chk("alui_mux", {MB_sel, MF_sel, MD_sel}, 3'b111);
    chk("alui_fn", G_sel, 4'd6);
    chk("alui_ld_done", {Load_en, done}, 2'b11);
    step();
    chk("alui_flags", flags, 4'b0101);
    // LD with ack in 4th MEM cycle
    instr = mk(4'd4, 2'd1, 2'd2, 2'd0, 2'd0, 4'd0, 8'h00); instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      req_cycles += int'(mem_req);
      chk("ld_wait", {mem_req, mem_we, Load_en, done, err}, 5'b10000);
      step();
    end
    mem_ack = 1'b1;
    #1;
    req_cycles += int'(mem_req);
    chk("ld_ack", {mem_req, mem_we, Load_en, MD_sel, done, err}, 6'b101010);
    chk("ld_dst", Dest_sel, 2'd1);
    step();
    mem_ack = 1'b0;
    #1;
    req_cycles += int'(mem_req);
    chk("ld_req_cycles", req_cycles, 4);
    chk("ld_after", {mem_req, done, instr_ready}, 3'b001);
    // ST with no ack: timeout on the 15th MEM cycle
    instr = mk(4'd5, 2'd0, 2'd3, 2'd2, 2'd0, 4'd0, 8'h00); instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      chk("st_wait", {mem_req, mem_we, Load_en, done, err}, 5'b11000);
      step();
    end
    chk("st_timeout", {mem_req, Load_en, done, err}, 4'b1011);
    step();
    chk("st_after", {mem_req, err, done, instr_ready}, 4'b0001);
    // Illegal opcode
    instr = mk(4'hF, 2'd3, 2'd3, 2'd3, 2'd3, 4'hF, 8'hFF); instr_valid = 1'b1; Tags = 4'b1111;
    step();
    instr_valid = 1'b0;
    chk("ill_exec", {Load_en, done, err, mem_req}, 4'b0110);
    step();
    chk("ill_flags", flags, 4'b0101);
    chk("ill_after", {done, err, instr_ready}, 3'b001);
    // Reset during second MEM cycle of LD
    instr = mk(4'd4, 2'd2, 2'd1, 2'd0, 2'd0, 4'd0, 8'h00); instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("rstmem_pre", mem_req, 1);
    step();
    chk("rstmem_post", {mem_req, instr_ready, done, Load_en, err}, 5'b01000);
    chk("rstmem_flags", flags, 0);
    rst = 1'b0;
    step();
    chk("rstmem_idle", {mem_req, instr_ready, done}, 3'b010);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
